axi4_read_arbiter: RTL and testbench

Shares one AXI4 read port (AR + R channels) between `NREQ` requesters in the DSI shield's memory path. Requester AR beats are arbitrated round-robin, registered and issued downstream with the requester index prepended to the ID; R beats are routed back by that ID prefix. A per-requester outstanding-burst counter throttles each requester to `MAX_OUTST` bursts in flight.

---
 rtl/axi4_read_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_axi4_read_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_read_arbiter.sv
// axi4_read_arbiter
// Shares one AXI4 read port (AR + R) between NREQ requesters.
// AR requests are granted round-robin, registered and issued downstream with
// the requester index prepended to the ID. R beats are steered back by that
// ID prefix. Each requester may have at most MAX_OUTST bursts in flight.
//
// Ports
//   ACLK, ARESET      clock, asynchronous active-high reset
//   s_ar*             per-requester AR channel (requester k in slice k)
//   s_r*              R channel back to requesters (payload broadcast)
//   m_ar*             downstream AR channel (registered payload)
//   m_r*              downstream R channel
//   busy              an AR is pending or any burst is still in flight
//   err_unexpected    one-cycle pulse: rlast for a requester with nothing in flight
//
// state | meaning
// IDLE  | arbitrating; s_arready driven for the winning requester
// ISSUE | m_arvalid held with a stable payload until m_arready

module axi4_read_arbiter #(
  parameter int NREQ      = 2,
  parameter int N         = 4,
  parameter int I         = 1,
  parameter int MAX_OUTST = 4,
  localparam int SW       = $clog2(NREQ)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [NREQ-1:0]   s_arvalid,
  output logic [NREQ-1:0]   s_arready,
  input  logic [NREQ*I-1:0] s_arid,
  input  logic [NREQ*32-1:0] s_araddr,
  input  logic [NREQ*8-1:0] s_arlen,
  input  logic [NREQ*3-1:0] s_arsize,
  input  logic [NREQ*2-1:0] s_arburst,
  output logic [NREQ-1:0]   s_rvalid,
  input  logic [NREQ-1:0]   s_rready,
  output logic [I-1:0]      s_rid,
  output logic [8*N-1:0]    s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [I+SW-1:0]   m_arid,
  output logic [31:0]       m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [I+SW-1:0]   m_rid,
  input  logic [8*N-1:0]    m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              busy,
  output logic              err_unexpected
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   last_q, last_d;
  logic [SW-1:0]   grant, idx;
  logic            grant_vld;
  logic [NREQ-1:0] elig;
  logic [CW-1:0]   outst_q [NREQ];
  logic [NREQ-1:0] inc_v, dec_v;
  logic            outst_nz;

  logic [I-1:0]    gnt_id;
  logic [31:0]     gnt_addr;
  logic [7:0]      gnt_len;
  logic [2:0]      gnt_size;
  logic [1:0]      gnt_burst;

  logic [I+SW-1:0] arid_q;
  logic [31:0]     araddr_q;
  logic [7:0]      arlen_q;
  logic [2:0]      arsize_q;
  logic [1:0]      arburst_q;

  logic [SW-1:0]   sel;
  logic            r_last_hs;
  logic            err_q, err_d;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      elig[k] = s_arvalid[k] && (outst_q[k] < CW'(MAX_OUTST));
    end
  end

  // Next state, arbitration and s_arready.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant     = last_q;
    idx       = '0;
    grant_vld = 1'b0;
    s_arready = '0;
    case (state_q)
      IDLE: begin
        // Walk from the farthest offset to the nearest so the nearest
        // eligible requester after last_q wins; offset NREQ is last_q itself.
        for (int i = NREQ; i >= 1; i--) begin
          idx = last_q + SW'(i);
          if (elig[idx]) grant = idx;
        end
        grant_vld = |elig;
        if (grant_vld) begin
          s_arready[grant] = 1'b1;
          last_d           = grant;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        if (m_arready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      last_q  <= SW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    gnt_id    = '0;
    gnt_addr  = '0;
    gnt_len   = '0;
    gnt_size  = '0;
    gnt_burst = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant == SW'(k)) begin
        gnt_id    = s_arid[I*k +: I];
        gnt_addr  = s_araddr[32*k +: 32];
        gnt_len   = s_arlen[8*k +: 8];
        gnt_size  = s_arsize[3*k +: 3];
        gnt_burst = s_arburst[2*k +: 2];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else if (grant_vld) begin
      arid_q    <= {grant, gnt_id};
      araddr_q  <= gnt_addr;
      arlen_q   <= gnt_len;
      arsize_q  <= gnt_size;
      arburst_q <= gnt_burst;
    end
  end

  assign m_arvalid = (state_q == ISSUE);
  assign m_arid    = arid_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = arsize_q;
  assign m_arburst = arburst_q;

  // R routing by the ID prefix added on the AR side.
  assign sel = m_rid[I+SW-1:I];

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      s_rvalid[k] = m_rvalid && (sel == SW'(k));
    end
  end

  assign m_rready  = s_rready[sel];
  assign s_rid     = m_rid[I-1:0];
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;
  assign r_last_hs = m_rvalid && m_rready && m_rlast;

  always_comb begin
    outst_nz = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      inc_v[k] = grant_vld && (grant == SW'(k));
      dec_v[k] = r_last_hs && (sel == SW'(k));
      if (outst_q[k] != '0) outst_nz = 1'b1;
    end
  end

  // Increment and decrement in the same cycle cancel; a decrement at zero
  // saturates and is reported through err_unexpected instead.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < NREQ; k++) outst_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (inc_v[k] && !dec_v[k]) begin
          outst_q[k] <= outst_q[k] + CW'(1);
        end else if (dec_v[k] && !inc_v[k] && (outst_q[k] != '0)) begin
          outst_q[k] <= outst_q[k] - CW'(1);
        end
      end
    end
  end

  assign err_d = r_last_hs && (outst_q[sel] == '0);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_unexpected = err_q;
  assign busy           = (state_q == ISSUE) || outst_nz;

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Testbench for axi4_read_arbiter (NREQ=2, N=4, I=1, MAX_OUTST=4).
// A negedge monitor keeps a reference model of grants, counters and the
// AR scoreboard; directed sequences and an R-routing vector table add
// explicit expectations.

module tb_axi4_read_arbiter;

  localparam int NREQ      = 2;
  localparam int N         = 4;
  localparam int I         = 1;
  localparam int MAX_OUTST = 4;
  localparam int SW        = 1;

  logic              ACLK;
  logic              ARESET;
  logic [NREQ-1:0]   s_arvalid, s_arready;
  logic [NREQ*I-1:0] s_arid;
  logic [NREQ*32-1:0] s_araddr;
  logic [NREQ*8-1:0] s_arlen;
  logic [NREQ*3-1:0] s_arsize;
  logic [NREQ*2-1:0] s_arburst;
  logic [NREQ-1:0]   s_rvalid, s_rready;
  logic [I-1:0]      s_rid;
  logic [8*N-1:0]    s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              m_arvalid, m_arready;
  logic [I+SW-1:0]   m_arid;
  logic [31:0]       m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_rvalid, m_rready;
  logic [I+SW-1:0]   m_rid;
  logic [8*N-1:0]    m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              busy, err_unexpected;

  axi4_read_arbiter #(.NREQ(NREQ), .N(N), .I(I), .MAX_OUTST(MAX_OUTST)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .busy(busy), .err_unexpected(err_unexpected)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  logic [46:0] exq[$];
  int          gq[$];

  int mo [NREQ];
  int mlast;
  bit mstate;
  bit merr;

  typedef struct {
    logic        rvalid;
    logic [1:0]  rid;
    logic [1:0]  rready;
    logic [31:0] rdata;
    logic [1:0]  exp_s_rvalid;
    logic        exp_m_rready;
    logic        exp_s_rid;
  } rvec_t;

  rvec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [46:0] pack_req(input int k);
    return {1'(k), s_arid[k +: 1], s_araddr[32*k +: 32], s_arlen[8*k +: 8],
            s_arsize[3*k +: 3], s_arburst[2*k +: 2]};
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge ACLK) begin : mon
    int eg, c, sel;
    bit hs, nerr, anyo;
    logic [1:0] exp_ar, exp_rv;
    logic [46:0] got;
    if (ARESET) begin
      for (int k = 0; k < NREQ; k++) mo[k] = 0;
      mlast  = NREQ - 1;
      mstate = 1'b0;
      merr   = 1'b0;
      exq.delete();
      check("rst_m_arvalid", 64'(m_arvalid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
    end else begin
      eg = -1;
      if (!mstate) begin
        for (int d = 1; d <= NREQ; d++) begin
          c = (mlast + d) % NREQ;
          if (eg < 0 && s_arvalid[c] && mo[c] < MAX_OUTST) eg = c;
        end
      end
      exp_ar = '0;
      if (eg >= 0) exp_ar[eg] = 1'b1;
      anyo = 1'b0;
      for (int k = 0; k < NREQ; k++) if (mo[k] != 0) anyo = 1'b1;
      check("s_arready", 64'(s_arready), 64'(exp_ar));
      check("m_arvalid", 64'(m_arvalid), 64'(mstate));
      check("busy", 64'(busy), 64'(mstate || anyo));
      check("err_unexpected", 64'(err_unexpected), 64'(merr));
      if (mstate && m_arready) begin
        if (exq.size() == 0) begin
          check("sb_underflow", 64'(exq.size()), 64'(1));
        end else begin
          got = {m_arid, m_araddr, m_arlen, m_arsize, m_arburst};
          check("m_ar_payload", 64'(got), 64'(exq.pop_front()));
        end
      end
      sel = int'(m_rid[1]);
      exp_rv = '0;
      if (m_rvalid) exp_rv[sel] = 1'b1;
      check("s_rvalid", 64'(s_rvalid), 64'(exp_rv));
      check("m_rready", 64'(m_rready), 64'(s_rready[sel]));
      check("s_rid", 64'(s_rid), 64'(m_rid[0]));
      check("s_rdata", 64'(s_rdata), 64'(m_rdata));
      check("s_rlast", 64'(s_rlast), 64'(m_rlast));
      check("s_rresp", 64'(s_rresp), 64'(m_rresp));
      hs   = m_rvalid && s_rready[sel] && m_rlast;
      nerr = hs && (mo[sel] == 0);
      if (eg >= 0 && !(hs && sel == eg)) mo[eg]++;
      if (hs && !(eg == sel) && mo[sel] > 0) mo[sel]--;
      if (eg >= 0) begin
        exq.push_back(pack_req(eg));
        gq.push_back(eg);
        mlast  = eg;
        mstate = 1'b1;
      end else if (mstate && m_arready) begin
        mstate = 1'b0;
      end
      merr = nerr;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
    gq.delete();
  endtask

  task automatic set_payload(input int k, input logic id, input logic [31:0] a, input logic [7:0] len);
    s_arid[k]             = id;
    s_araddr[32*k +: 32]  = a;
    s_arlen[8*k +: 8]     = len;
    s_arsize[3*k +: 3]    = 3'd2;
    s_arburst[2*k +: 2]   = 2'd1;
  endtask

  task automatic issue(input int k);
    int n;
    set_payload(k, 1'($urandom), 32'($urandom), 8'($urandom_range(0, 15)));
    s_arvalid[k] = 1'b1;
    #1;
    n = 0;
    while (!s_arready[k] && n < 20) begin
      tick();
      n++;
    end
    check("issue_grant", 64'(s_arready[k]), 64'(1));
    tick();
    s_arvalid[k] = 1'b0;
    if (m_arready) tick();
  endtask

  task automatic r_beat(input logic [1:0] rid, input logic [1:0] rdy, input logic last);
    m_rvalid = 1'b1;
    m_rid    = rid;
    s_rready = rdy;
    m_rlast  = last;
    m_rdata  = 32'($urandom);
    m_rresp  = 2'($urandom);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr [8];
    logic [31:0] hold_addr;
    exp_rr = '{0, 1, 0, 1, 0, 1, 0, 1};

    tbl[0] = '{1'b1, 2'b00, 2'b01, 32'hA5A5_0001, 2'b01, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 2'b01, 2'b01, 32'h1234_5678, 2'b01, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 2'b10, 2'b10, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 2'b11, 2'b01, 32'h0F0F_F0F0, 2'b10, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 2'b10, 2'b11, 32'h0000_0000, 2'b00, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 2'b10, 2'b01, 32'hFFFF_FFFF, 2'b10, 1'b0, 1'b0};

    ARESET = 1'b1;
    s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0; s_rready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0;
    m_rresp = '0; m_rlast = 1'b0;
    tick();
    tick();
    ARESET = 1'b0;
    #1;
    check("reset_m_arvalid", 64'(m_arvalid), 64'(0));
    check("reset_m_arid", 64'(m_arid), 64'(0));
    check("reset_m_araddr", 64'(m_araddr), 64'(0));
    check("reset_m_arlen", 64'(m_arlen), 64'(0));
    check("reset_m_arsize_burst", 64'({m_arsize, m_arburst}), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_err", 64'(err_unexpected), 64'(0));

    // Single request from requester 0, then its 4-beat burst.
    m_arready = 1'b1;
    set_payload(0, 1'b1, 32'h0000_1000, 8'd3);
    s_arvalid = 2'b01;
    #1;
    check("single_s_arready", 64'(s_arready), 64'(2'b01));
    tick();
    s_arvalid = 2'b00;
    #1;
    check("single_m_arvalid_t1", 64'(m_arvalid), 64'(1));
    check("single_m_arid", 64'(m_arid), 64'(2'b01));
    check("single_m_araddr", 64'(m_araddr), 64'(32'h1000));
    check("single_m_arlen", 64'(m_arlen), 64'(3));
    tick();
    check("single_m_arvalid_t2", 64'(m_arvalid), 64'(0));
    check("single_busy_outst", 64'(busy), 64'(1));
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      m_rid    = 2'b01;
      s_rready = 2'b01;
      m_rlast  = (b == 3);
      m_rdata  = 32'($urandom);
      #1;
      check("single_s_rvalid", 64'(s_rvalid), 64'(2'b01));
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    check("single_busy_done", 64'(busy), 64'(0));
    check("single_err", 64'(err_unexpected), 64'(0));

    // R routing vectors.
    for (int i = 0; i < 6; i++) begin
      m_rvalid = tbl[i].rvalid;
      m_rid    = tbl[i].rid;
      s_rready = tbl[i].rready;
      m_rdata  = tbl[i].rdata;
      m_rlast  = 1'b0;
      #1;
      check("tbl_s_rvalid", 64'(s_rvalid), 64'(tbl[i].exp_s_rvalid));
      check("tbl_m_rready", 64'(m_rready), 64'(tbl[i].exp_m_rready));
      check("tbl_s_rid", 64'(s_rid), 64'(tbl[i].exp_s_rid));
      check("tbl_s_rdata", 64'(s_rdata), 64'(tbl[i].rdata));
      tick();
    end
    m_rvalid = 1'b0;
    s_rready = 2'b00;

    // Round-robin until both requesters hit the outstanding limit.
    do_reset();
    m_arready = 1'b1;
    set_payload(0, 1'b0, 32'h0000_2000, 8'd1);
    set_payload(1, 1'b1, 32'h0000_3000, 8'd7);
    s_arvalid = 2'b11;
    repeat (20) tick();
    check("rr_grant_count", 64'(gq.size()), 64'(8));
    for (int i = 0; i < gq.size() && i < 8; i++) check("rr_grant_order", 64'(gq[i]), 64'(exp_rr[i]));
    check("rr_stall_arready", 64'(s_arready), 64'(0));
    check("rr_stall_busy", 64'(busy), 64'(1));
    s_arvalid = 2'b00;

    // Throttle: requester 0 full, requester 1 gets through.
    do_reset();
    m_arready = 1'b1;
    set_payload(0, 1'b1, 32'h0000_4000, 8'd0);
    s_arvalid = 2'b01;
    repeat (10) tick();
    check("thr_r0_full_grants", 64'(gq.size()), 64'(4));
    gq.delete();
    set_payload(1, 1'b0, 32'h0000_5000, 8'd2);
    s_arvalid = 2'b11;
    #1;
    check("thr_r1_granted", 64'(s_arready), 64'(2'b10));
    tick();
    s_arvalid = 2'b01;
    tick();
    m_rvalid = 1'b1; m_rid = 2'b00; s_rready = 2'b01; m_rlast = 1'b1;
    #1;
    check("thr_r0_blocked", 64'(s_arready), 64'(0));
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    check("thr_r0_regrant", 64'(s_arready), 64'(2'b01));
    tick();
    s_arvalid = 2'b00;
    tick();
    check("thr_grant_count", 64'(gq.size()), 64'(2));
    if (gq.size() >= 2) begin
      check("thr_order_0", 64'(gq[0]), 64'(1));
      check("thr_order_1", 64'(gq[1]), 64'(0));
    end

    // AR backpressure: payload held, no new grants while stalled.
    do_reset();
    m_arready = 1'b0;
    hold_addr = 32'($urandom);
    set_payload(1, 1'b1, hold_addr, 8'd5);
    s_arvalid = 2'b10;
    #1;
    check("bp_grant_r1", 64'(s_arready), 64'(2'b10));
    tick();
    set_payload(0, 1'b0, 32'h0000_6000, 8'd4);
    s_arvalid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_m_arvalid", 64'(m_arvalid), 64'(1));
      check("bp_m_araddr", 64'(m_araddr), 64'(hold_addr));
      check("bp_m_arid", 64'(m_arid), 64'(2'b11));
      check("bp_no_arready", 64'(s_arready), 64'(0));
      tick();
    end
    m_arready = 1'b1;
    tick();
    check("bp_released", 64'(m_arvalid), 64'(0));
    check("bp_next_grant", 64'(s_arready), 64'(2'b01));
    tick();
    s_arvalid = 2'b00;
    tick();
    m_rvalid = 1'b1; m_rid = 2'b10; s_rready = 2'b01; m_rlast = 1'b0;
    #1;
    check("bp_m_rready_low", 64'(m_rready), 64'(0));
    check("bp_s_rvalid", 64'(s_rvalid), 64'(2'b10));
    tick();
    m_rvalid = 1'b0;

    // Simultaneous grant and rlast on requester 0 with 2 outstanding.
    do_reset();
    m_arready = 1'b1;
    issue(0);
    issue(0);
    set_payload(0, 1'b1, 32'h0000_7000, 8'd1);
    s_arvalid = 2'b01;
    m_rvalid = 1'b1; m_rid = 2'b00; s_rready = 2'b01; m_rlast = 1'b1;
    #1;
    check("sim_grant", 64'(s_arready), 64'(2'b01));
    check("sim_m_rready", 64'(m_rready), 64'(1));
    tick();
    s_arvalid = 2'b00;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    tick();
    r_beat(2'b00, 2'b01, 1'b1);
    check("sim_busy_after_1", 64'(busy), 64'(1));
    r_beat(2'b00, 2'b01, 1'b1);
    check("sim_busy_after_2", 64'(busy), 64'(0));
    check("sim_no_err", 64'(err_unexpected), 64'(0));

    // Stray rlast for requester 1 with nothing in flight.
    r_beat(2'b10, 2'b10, 1'b1);
    check("stray_err_pulse", 64'(err_unexpected), 64'(1));
    tick();
    check("stray_err_clear", 64'(err_unexpected), 64'(0));
    check("stray_busy", 64'(busy), 64'(0));

    // Reset while ISSUE is pending with 3 bursts outstanding.
    do_reset();
    m_arready = 1'b1;
    issue(0);
    issue(1);
    m_arready = 1'b0;
    set_payload(0, 1'b0, 32'h0000_8000, 8'd2);
    s_arvalid = 2'b01;
    tick();
    s_arvalid = 2'b00;
    #1;
    check("rstiss_pending", 64'(m_arvalid), 64'(1));
    ARESET = 1'b1;
    #1;
    check("rstiss_m_arvalid", 64'(m_arvalid), 64'(0));
    check("rstiss_busy", 64'(busy), 64'(0));
    tick();
    tick();
    gq.delete();
    m_arready = 1'b1;
    set_payload(1, 1'b1, 32'h0000_9000, 8'd0);
    s_arvalid = 2'b11;
    ARESET = 1'b0;
    #1;
    check("rstiss_first_grant", 64'(s_arready), 64'(2'b01));
    tick();
    s_arvalid = 2'b00;
    tick();
    tick();
    check("rstiss_gq_size", 64'(gq.size()), 64'(1));
    if (gq.size() >= 1) check("rstiss_gq_first", 64'(gq[0]), 64'(0));

    check("sb_drain", 64'(exq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
